// File: rtl/fetch_prefetch.sv
// Decoupled instruction prefetcher: issues sequential reads from its own fetch PC and
// queues {instr, pc} in a DEPTH-entry FIFO drained by decode through valid/ready.
module fetch_prefetch #(
    parameter int              AW       = 16,
    parameter int              DW       = 16,
    parameter int              DEPTH    = 4,
    parameter logic [AW-1:0]   RESET_PC = 16'h3000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable_fetch,
    input  logic                       br_taken,
    input  logic [AW-1:0]              taddr,
    output logic                       Imem_rd,
    output logic [AW-1:0]              Imem_addr,
    input  logic [DW-1:0]              Imem_dout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_instr,
    output logic [AW-1:0]              out_pc,
    output logic [AW-1:0]              out_npc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;
    localparam int EW  = DW + AW;
    localparam logic [AW-1:0]  ONE_A   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]  ONE_P   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW1-1:0] DEPTH_V = CW1'(DEPTH);

    logic [EW-1:0]  mem_r [DEPTH];
    logic [AW-1:0]  fpc_r;
    logic [AW-1:0]  ipc_r;
    logic           inflight_r;
    logic [CW-1:0]  count_r;
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;

    logic           pop_s;
    logic           push_s;
    logic           issue_s;
    logic [CW1-1:0] need_s;
    logic [EW-1:0]  head_s;

    // Credit check: entries held plus the one in flight, minus the one leaving now.
    always_comb begin
        pop_s   = out_valid & out_ready;
        push_s  = inflight_r & ~br_taken;
        need_s  = CW1'(count_r) + CW1'(inflight_r) - CW1'(pop_s);
        issue_s = 1'b0;
        if (!rst && enable_fetch && !br_taken && (need_s < DEPTH_V)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Fetch PC, in-flight tracking and FIFO storage; a redirect wipes everything queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_r      <= RESET_PC;
            ipc_r      <= RESET_PC;
            inflight_r <= 1'b0;
            count_r    <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (br_taken) begin
            fpc_r      <= taddr;
            inflight_r <= 1'b0;
            count_r    <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                fpc_r <= fpc_r + ONE_A;
                ipc_r <= fpc_r;
            end
            // Writing the head slot while it is popped is safe: the pop retires it at this edge.
            if (push_s) begin
                mem_r[wr_ptr_r] <= {Imem_dout, ipc_r};
                wr_ptr_r        <= wr_ptr_r + ONE_P;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_P;
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    assign head_s    = mem_r[rd_ptr_r];
    assign out_valid = (count_r != '0);
    assign out_instr = head_s[EW-1:AW];
    assign out_pc    = head_s[AW-1:0];
    assign out_npc   = head_s[AW-1:0] + ONE_A;
    assign count     = count_r;
    assign Imem_rd   = issue_s;
    assign Imem_addr = fpc_r;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: behavioural instruction memory, a fetch-address
// model and a queue scoreboard of expected {pc, npc, instr} for every accepted entry.
module tb_fetch_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_fetch = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] taddr = 16'h0000;
    logic        Imem_rd;
    logic [15:0] Imem_addr;
    logic [15:0] Imem_dout = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] out_npc;
    logic [2:0]  count;

    int          n_checks = 0;
    int          n_fail = 0;
    int          rd_cnt = 0;
    int          pop_cnt = 0;
    bit          mon_en = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_fetch = 16'h3000;
    logic [15:0] mon_e;

    always #5 clk = ~clk;

    fetch_prefetch #(.AW(16), .DW(16), .DEPTH(4), .RESET_PC(16'h3000)) dut (
        .clk(clk), .rst(rst), .enable_fetch(enable_fetch), .br_taken(br_taken),
        .taddr(taddr), .Imem_rd(Imem_rd), .Imem_addr(Imem_addr), .Imem_dout(Imem_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_npc(out_npc), .count(count)
    );

    function automatic logic [15:0] exp_instr(input logic [15:0] pc);
        return 16'h1000 + {12'h000, pc[3:0]};
    endfunction

    // Instruction memory with one-cycle read latency.
    always @(posedge clk) begin
        if (Imem_rd) Imem_dout <= exp_instr(Imem_addr);
    end

    // Monitor: every issued address and every accepted head entry is checked mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (Imem_rd) begin
                    rd_cnt++;
                    n_checks++;
                    if (br_taken) begin
                        n_fail++;
                        $display("FAIL rd_in_redirect: Imem_rd=1 addr=%h, required Imem_rd=0", Imem_addr);
                    end else if (Imem_addr !== exp_fetch) begin
                        n_fail++;
                        $display("FAIL fetch_addr: got %h required %h", Imem_addr, exp_fetch);
                    end
                    exp_fetch = exp_fetch + 16'h0001;
                end
                if (out_valid && out_ready && !br_taken) begin
                    pop_cnt++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_underflow: unexpected entry pc=%h", out_pc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (out_pc !== mon_e || out_npc !== mon_e + 16'h0001 || out_instr !== exp_instr(mon_e)) begin
                            n_fail++;
                            $display("FAIL sb_entry: got pc=%h npc=%h instr=%h required pc=%h npc=%h instr=%h",
                                     out_pc, out_npc, out_instr, mon_e, mon_e + 16'h0001, exp_instr(mon_e));
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_start(input logic [15:0] a);
        logic [15:0] p;
        p = a;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(p);
            p = p + 16'h0001;
        end
        exp_fetch = a;
    endtask

    task automatic test_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_checks++; if (Imem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_imem_rd: got %b required 0", Imem_rd); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", count); end
        n_checks++; if (Imem_addr !== 16'h3000) begin n_fail++; $display("FAIL reset_imem_addr: got %h required 3000", Imem_addr); end
        rst = 1'b0;
        #1;
        n_checks++; if (Imem_rd !== 1'b0) begin n_fail++; $display("FAIL idle_no_issue: got %b required 0", Imem_rd); end
    endtask

    task automatic test_stream();
        int p0;
        sb_start(16'h3000);
        mon_en = 1'b1;
        enable_fetch = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++; if (Imem_rd !== 1'b1 || Imem_addr !== 16'h3000) begin n_fail++; $display("FAIL first_issue: rd=%b addr=%h required rd=1 addr=3000", Imem_rd, Imem_addr); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: out_valid=%b required 0", out_valid); end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'h3000 || out_npc !== 16'h3001 || out_instr !== 16'h1000) begin
            n_fail++;
            $display("FAIL first_out: valid=%b pc=%h npc=%h instr=%h required 1 3000 3001 1000", out_valid, out_pc, out_npc, out_instr);
        end
        p0 = pop_cnt;
        repeat (10) step();
        n_checks++; if (pop_cnt - p0 !== 10) begin n_fail++; $display("FAIL throughput: got %0d pops required 10", pop_cnt - p0); end
    endtask

    task automatic test_backpressure();
        int r0;
        int p0;
        enable_fetch = 1'b0;
        repeat (4) step();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL bp_drain: count=%0d required 0", count); end
        r0 = rd_cnt;
        out_ready = 1'b0;
        enable_fetch = 1'b1;
        repeat (8) step();
        n_checks++; if (rd_cnt - r0 !== 4) begin n_fail++; $display("FAIL bp_reads: got %0d required 4", rd_cnt - r0); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL bp_full: count=%0d required 4", count); end
        n_checks++; if (Imem_rd !== 1'b0) begin n_fail++; $display("FAIL bp_stall: Imem_rd=%b required 0", Imem_rd); end
        r0 = rd_cnt;
        p0 = pop_cnt;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (5) step();
        n_checks++; if (rd_cnt - r0 !== 1) begin n_fail++; $display("FAIL bp_one_more: got %0d reads required 1", rd_cnt - r0); end
        n_checks++; if (pop_cnt - p0 !== 1) begin n_fail++; $display("FAIL bp_one_pop: got %0d pops required 1", pop_cnt - p0); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL bp_refill: count=%0d required 4", count); end
    endtask

    task automatic test_redirect();
        enable_fetch = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        out_ready = 1'b0;
        enable_fetch = 1'b1;
        repeat (3) step();
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL redir_setup: count=%0d required 2", count); end
        br_taken = 1'b1;
        taddr = 16'h3050;
        sb_start(16'h3050);
        #1;
        n_checks++; if (Imem_rd !== 1'b0) begin n_fail++; $display("FAIL redir_no_issue: Imem_rd=%b required 0", Imem_rd); end
        step();
        br_taken = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: count=%0d valid=%b required 0 0", count, out_valid); end
        n_checks++; if (Imem_rd !== 1'b1 || Imem_addr !== 16'h3050) begin n_fail++; $display("FAIL redir_target: rd=%b addr=%h required 1 3050", Imem_rd, Imem_addr); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_gap: out_valid=%b required 0", out_valid); end
        step();
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 16'h3050) begin n_fail++; $display("FAIL redir_first: valid=%b pc=%h required 1 3050", out_valid, out_pc); end
        out_ready = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_redirect_full_pop();
        int p0;
        out_ready = 1'b0;
        repeat (8) step();
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL rfp_full: count=%0d required 4", count); end
        br_taken = 1'b1;
        taddr = 16'h4000;
        out_ready = 1'b1;
        sb_start(16'h4000);
        p0 = pop_cnt;
        step();
        br_taken = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rfp_flush: count=%0d valid=%b required 0 0", count, out_valid); end
        n_checks++; if (Imem_rd !== 1'b1 || Imem_addr !== 16'h4000) begin n_fail++; $display("FAIL rfp_restart: rd=%b addr=%h required 1 4000", Imem_rd, Imem_addr); end
        repeat (8) step();
        n_checks++; if (pop_cnt - p0 !== 6) begin n_fail++; $display("FAIL rfp_pops: got %0d required 6", pop_cnt - p0); end
    endtask

    task automatic test_wrap();
        br_taken = 1'b1;
        taddr = 16'hFFFE;
        sb_start(16'hFFFE);
        step();
        br_taken = 1'b0;
        repeat (2) step();
        n_checks++; if (out_pc !== 16'hFFFE || out_npc !== 16'hFFFF || out_instr !== 16'h100E) begin n_fail++; $display("FAIL wrap0: pc=%h npc=%h instr=%h required FFFE FFFF 100E", out_pc, out_npc, out_instr); end
        step();
        n_checks++; if (out_pc !== 16'hFFFF || out_npc !== 16'h0000 || out_instr !== 16'h100F) begin n_fail++; $display("FAIL wrap1: pc=%h npc=%h instr=%h required FFFF 0000 100F", out_pc, out_npc, out_instr); end
        step();
        n_checks++; if (out_pc !== 16'h0000 || out_npc !== 16'h0001 || out_instr !== 16'h1000) begin n_fail++; $display("FAIL wrap2: pc=%h npc=%h instr=%h required 0000 0001 1000", out_pc, out_npc, out_instr); end
        repeat (3) step();
    endtask

    task automatic test_async_reset();
        int p0;
        enable_fetch = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        out_ready = 1'b0;
        enable_fetch = 1'b1;
        repeat (4) step();
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL ar_setup: count=%0d required 3", count); end
        mon_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || Imem_rd !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL ar_immediate: valid=%b rd=%b count=%0d required 0 0 0", out_valid, Imem_rd, count);
        end
        @(posedge clk);
        #2;
        sb_start(16'h3000);
        rst = 1'b0;
        out_ready = 1'b1;
        mon_en = 1'b1;
        #1;
        n_checks++; if (Imem_rd !== 1'b1 || Imem_addr !== 16'h3000) begin n_fail++; $display("FAIL ar_restart: rd=%b addr=%h required 1 3000", Imem_rd, Imem_addr); end
        p0 = pop_cnt;
        repeat (6) step();
        n_checks++; if (pop_cnt - p0 !== 4) begin n_fail++; $display("FAIL ar_stream: got %0d pops required 4", pop_cnt - p0); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_full_pop();
        test_wrap();
        test_async_reset();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
